// File: rtl/incr_share_ctrl.sv
// rtl/incr_share_ctrl.sv - round-robin owner of one shared WIDTH-bit incrementer among four requesters

module incr_share_unit #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    output logic [WIDTH:0]   y_o
);
    assign y_o = {1'b0, a_i} + {{WIDTH{1'b0}}, 1'b1};
endmodule

module incr_share_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] ops,
    output logic [3:0]         grant,
    output logic [3:0]         done,
    output logic [WIDTH:0]     result,
    output logic               busy,
    output logic [7:0]         op_count
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RESULT} state_t;

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [3:0]       grant_q, grant_d;
    logic [3:0]       done_q, done_d;
    logic [WIDTH:0]   result_q, result_d;
    logic [WIDTH-1:0] op_reg_q, op_reg_d;
    logic [7:0]       count_q, count_d;

    logic [1:0]       win;
    logic             win_vld;
    logic [WIDTH-1:0] op_sel;
    logic [WIDTH:0]   inc_sum;

    // First requester at or after ptr, wrapping modulo 4.
    always_comb begin
        logic [1:0] idx;
        win     = '0;
        win_vld = 1'b0;
        op_sel  = '0;
        idx     = '0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + k[1:0];
            if (!win_vld && req[idx]) begin
                win     = idx;
                win_vld = 1'b1;
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (win == k[1:0]) op_sel = ops[k*WIDTH +: WIDTH];
        end
    end

    incr_share_unit #(.WIDTH(WIDTH)) u_inc (
        .a_i (op_reg_q),
        .y_o (inc_sum)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        done_d   = 4'b0000;
        result_d = result_q;
        op_reg_d = op_reg_q;
        count_d  = count_q;
        unique case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    state_d  = S_LOAD;
                    grant_d  = 4'b0001 << win;
                    op_reg_d = op_sel;
                    ptr_d    = win + 2'd1;
                end
            end
            S_LOAD: begin
                state_d  = S_RESULT;
                result_d = inc_sum;
                done_d   = grant_q;
                count_d  = count_q + 8'd1;
            end
            S_RESULT: begin
                state_d = S_IDLE;
                grant_d = 4'b0000;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            result_q <= '0;
            op_reg_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            result_q <= result_d;
            op_reg_q <= op_reg_d;
            count_q  <= count_d;
        end
    end

    assign grant    = grant_q;
    assign done     = done_q;
    assign result   = result_q;
    assign busy     = (state_q != S_IDLE);
    assign op_count = count_q;
endmodule

// File: tb/tb_incr_share_ctrl.sv
// tb/tb_incr_share_ctrl.sv - directed scoreboard bench for incr_share_ctrl

module tb_incr_share_ctrl;
    localparam int WIDTH = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [3:0]         req = '0;
    logic [4*WIDTH-1:0] ops = '0;
    logic [3:0]         grant;
    logic [3:0]         done;
    logic [WIDTH:0]     result;
    logic               busy;
    logic [7:0]         op_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_done_cyc = 0;
    bit saw_done = 1'b0;
    logic [7:0] exp_count = '0;

    typedef struct packed {
        logic [3:0]     owner;
        logic [WIDTH:0] res;
    } exp_t;
    exp_t sb[$];

    incr_share_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .ops      (ops),
        .grant    (grant),
        .done     (done),
        .result   (result),
        .busy     (busy),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] owner, input logic [WIDTH:0] res);
        exp_t e;
        e.owner = owner;
        e.res   = res;
        sb.push_back(e);
    endtask

    // Advance one cycle; any done pulse is matched against the scoreboard head.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        saw_done = 1'b0;
        if (done !== 4'b0000) begin
            saw_done = 1'b1;
            last_done_cyc = cyc;
            if (sb.size() == 0) begin
                check("unexpected_done", {28'd0, done}, 32'd0);
            end else begin
                e = sb.pop_front();
                exp_count = exp_count + 8'd1;
                check("done_owner", {28'd0, done}, {28'd0, e.owner});
                check("grant_at_done", {28'd0, grant}, {28'd0, e.owner});
                check("result", {27'd0, result}, {27'd0, e.res});
                check("op_count", {24'd0, op_count}, {24'd0, exp_count});
            end
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!saw_done && n < 12);
        if (!saw_done) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int prev;
        // Reset state
        #1;
        check("rst_grant", {28'd0, grant}, 32'd0);
        check("rst_done", {28'd0, done}, 32'd0);
        check("rst_result", {27'd0, result}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_count", {24'd0, op_count}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();

        // All four requesting and held: strict rotation every 3 cycles
        ops = {4'd4, 4'd3, 4'd2, 4'd1};
        req = 4'b1111;
        push(4'b0001, 5'd2);
        push(4'b0010, 5'd3);
        push(4'b0100, 5'd4);
        push(4'b1000, 5'd5);
        push(4'b0001, 5'd2);
        wait_done("rr0");
        for (int i = 1; i < 5; i++) begin
            prev = last_done_cyc;
            wait_done("rr");
            check("rr_spacing", last_done_cyc - prev, 32'd3);
        end
        req = 4'b0000;
        repeat (2) tick();

        // Single request, operand 5 (ptr=1, wraps to requester 0)
        ops = {4'd0, 4'd0, 4'd0, 4'd5};
        req = 4'b0001;
        push(4'b0001, 5'h06);
        tick();
        check("single_grant", {28'd0, grant}, 32'h1);
        check("single_busy", {31'd0, busy}, 32'd1);
        tick();
        check("single_done_seen", {31'd0, saw_done}, 32'd1);
        req = 4'b0000;
        tick();
        check("single_busy_low", {31'd0, busy}, 32'd0);
        check("single_grant_low", {28'd0, grant}, 32'd0);
        check("single_done_low", {28'd0, done}, 32'd0);
        tick();

        // Overflow, operand 0xF on requester 2
        ops[11:8] = 4'hF;
        req = 4'b0100;
        push(4'b0100, 5'h10);
        wait_done("ovf");
        req = 4'b0000;
        repeat (2) tick();

        // Fairness after pointer moved to 3: requester 0 first, then 2
        req = 4'b0101;
        push(4'b0001, 5'h06);
        push(4'b0100, 5'h10);
        tick();
        check("fair_grant0", {28'd0, grant}, 32'h1);
        wait_done("fair0");
        req = 4'b0100;
        tick();
        tick();
        check("fair_grant2", {28'd0, grant}, 32'h4);
        wait_done("fair2");
        req = 4'b0000;
        repeat (2) tick();

        // Operand change and req drop after capture
        ops[7:4] = 4'd7;
        req = 4'b0010;
        push(4'b0010, 5'h08);
        tick();
        check("mid_grant", {28'd0, grant}, 32'h2);
        ops[7:4] = 4'd9;
        req = 4'b0000;
        wait_done("mid");
        repeat (2) tick();

        // Reset during LOAD: everything clears, no done, no count
        req = 4'b0001;
        tick();
        check("rstmid_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        req = 4'b0000;
        #1;
        exp_count = 8'd0;
        check("rstmid_grant", {28'd0, grant}, 32'd0);
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        check("rstmid_done", {28'd0, done}, 32'd0);
        check("rstmid_result", {27'd0, result}, 32'd0);
        check("rstmid_count", {24'd0, op_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) tick();
        check("rstmid_no_done_count", {24'd0, op_count}, 32'd0);

        // 256 completions wrap the counter to 0
        ops[3:0] = 4'd5;
        req = 4'b0001;
        for (int i = 0; i < 256; i++) push(4'b0001, 5'h06);
        for (int i = 0; i < 256; i++) wait_done("wrap");
        req = 4'b0000;
        repeat (2) tick();
        check("wrap_count", {24'd0, op_count}, 32'd0);
        check("sb_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/incr_share_ctrl.md
# incr_share_ctrl

Round-robin controller that shares one WIDTH-bit incrementer datapath among four requesters. It arbitrates requests, latches the winning requester's operand, and drives the shared incrementer. It then returns the (WIDTH+1)-bit sum with carry to the winner through a one-cycle done pulse. It sits between the register-file/counter clients and the single gate-level incrementer instance, so that only one adder chain exists in the design.

## Interface
- WIDTH, 4, operand width; result is WIDTH+1 bits (carry in MSB).
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  4  per-requester request level; bit i = requester i.
- ops  in  4*WIDTH  packed operands; requester i uses ops[i*WIDTH +: WIDTH].
- grant  out  4  one-hot owner of the datapath, held from LOAD through RESULT; 0 in IDLE.
- done  out  4  one-hot, one-cycle pulse to the owner when its result is valid.
- result  out  WIDTH+1  registered operand+1 of the last completed op; holds until the next completion.
- busy  out  1  high in LOAD and RESULT.
- op_count  out  8  number of completed ops; wraps 255->0.

## Operation
- States:
  - IDLE: no owner.
  - LOAD: operand latched; incrementer computing.
  - RESULT: sum registered; done pulse active.
- Transitions:
  - IDLE -> LOAD when req != 0.
  - LOAD -> RESULT unconditionally.
  - RESULT -> IDLE unconditionally.
  - No back-to-back arbitration: every op occupies 3 cycles, including the IDLE cycle.
- Arbitration, evaluated only in IDLE:
  - Round-robin starting at pointer ptr (2 bits, reset 0).
  - Winner is the first i in ptr, ptr+1, ... (mod 4) with req[i]=1.
  - On grant, ptr <= (winner+1) mod 4.
  - ptr does not change otherwise.
- Operand capture:
  - At the IDLE->LOAD edge, ops slice of the winner is copied into op_reg (WIDTH bits).
  - Later changes to ops or req have no effect on the op in flight.
- Datapath:
  - Shared incrementer computes {carry, sum} = op_reg + 1 in WIDTH+1 bits; no other carry-in.
  - All-ones operand gives result = 1 followed by WIDTH zeros.
  - Carry is never dropped.
- Completion, at the LOAD->RESULT edge:
  - result <= incrementer output.
  - done[owner] <= 1.
  - op_count <= op_count+1 (mod 256).
- Requester handshake:
  - Requester asserts req[i] with a stable operand.
  - It holds req[i] until it sees done[i]=1.
  - It must deassert req[i] in the cycle after done, unless it wants another op.
  - req[i] still high in IDLE is treated as a new request.
  - req dropped while the requester is owner is ignored: the op completes and done is still pulsed.
- Reset values (asynchronous on rst_n=0, in any state including mid-op):
  - state = IDLE.
  - grant = 0, done = 0, busy = 0.
  - result = 0, op_count = 0, ptr = 0, op_reg = 0.
  - An op interrupted by reset produces no done and no count increment.

## Timing
- Edge numbering: req sampled high at edge E0 in IDLE.
- After E0:
  - grant one-hot and busy=1 become visible.
  - ops is sampled at E0.
- After E1:
  - result valid and done pulse high for exactly one cycle.
  - grant still high.
  - op_count incremented.
- After E2: state IDLE, grant=0, busy=0, done=0.
- Earliest next grant is visible after E3.
- Latency is 2 cycles from request edge to done; sustained throughput is 1 op per 3 cycles.
- Simultaneous requests: exactly one grant per arbitration. Losers wait with no timeout and no starvation; worst-case wait is 3 ops (9 cycles).
- Outputs are registered; there is no combinational path from req or ops to any output.

## Test plan
- Single request, operand 5:
  - Stimulus: req=0001, ops[3:0]=5 (WIDTH=4).
  - Response: grant=0001 after E0; done=0001 and result=0x06 after E1; busy low after E2; op_count=1.
- Overflow, operand 0xF:
  - Stimulus: req=0100, ops[11:8]=0xF.
  - Response: result=0x10 (carry=1, sum=0), done=0100.
- All four requesting, held:
  - Stimulus: req=1111 held, with ops 1, 2, 3, 4.
  - Response: grants 0001, 0010, 0100, 1000 in order, every 3 cycles; results 2, 3, 4, 5; then back to 0001.
- Fairness after pointer move:
  - Stimulus: grant to requester 2 completes, then req=0101.
  - Response: next grant=0001 (ptr=3, wraps past 3 to 0), then 0100.
- Operand change and req drop mid-op:
  - Stimulus: requester 1 wins with op 7; ops[7:4] changed to 9 and req[1] dropped after E0.
  - Response: result=0x08, done=0010.
- Reset mid-op and count wrap:
  - Stimulus: rst_n low in LOAD.
  - Response: no done; all outputs 0 immediately.
  - Stimulus: 256 completed ops.
  - Response: op_count reads 0.
